apb_master: RTL

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 138 +++++++++++++
 1 files changed

// File: rtl/apb_master.sv
// APB-style bus master: accepts one command at a time, runs SETUP/ACCESS on the bus
// and returns a single-cycle response with read data or an error flag.
module apb_master #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int MIN_WAIT   = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [1:0]            cmd_id,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [1:0]            sel,
   output logic                  write,
   output logic                  enable,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic                  ready
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   localparam logic [8:0] MIN_W = 9'(MIN_WAIT);
   localparam logic [8:0] TMO   = 9'(TIMEOUT);

   state_t                 state_q, state_d;
   logic [1:0]             id_q, id_d;
   logic                   write_q, write_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic [7:0]             cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
   logic                   err_q, err_d;
   logic [8:0]             cnt_inc;
   logic                   done, expire;

   // Count of ACCESS cycles including the current one.
   assign cnt_inc = {1'b0, cnt_q} + 9'd1;
   assign done    = ready && (cnt_inc >= MIN_W);
   assign expire  = cnt_inc >= TMO;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         id_q    <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      write_d   = write_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      sel       = 2'd0;
      write     = 1'b0;
      enable    = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               id_d    = cmd_id;
               write_d = cmd_write;
               // Bus address/data only change for a real transfer so they hold otherwise.
               if (cmd_id != 2'd0) begin
                  addr_d  = cmd_addr;
                  wdata_d = cmd_wdata;
                  state_d = SETUP;
               end else begin
                  rdata_d = '0;
                  err_d   = 1'b1;
                  state_d = RESP;
               end
            end
         end
         SETUP: begin
            sel     = id_q;
            write   = write_q;
            cnt_d   = 8'd0;
            state_d = ACCESS;
         end
         ACCESS: begin
            sel    = id_q;
            write  = write_q;
            enable = 1'b1;
            cnt_d  = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
            if (done) begin
               rdata_d = write_q ? '0 : rdata;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (expire) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign addr      = addr_q;
   assign wdata     = wdata_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule
